// File: rtl/attack_judge_pkg.sv
// Shared constants for the attack judge: FSM encoding, idle game state, LFSR taps.
package attack_judge_pkg;

  localparam logic [1:0] FSM_IDLE     = 2'd0;
  localparam logic [1:0] FSM_WAIT     = 2'd1;
  localparam logic [1:0] FSM_APPROACH = 2'd2;

  localparam logic [3:0] STATE_IDLE = 4'd0;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/attack_judge_btn_edge.sv
// Button synchroniser plus rising-edge detector; press is a registered 1-cycle pulse
// appearing 3 edges after btn is first sampled high; no backpressure.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      prev  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      prev  <= sync[1];
      press <= sync[1] & ~prev;
    end
  end

endmodule

// File: rtl/attack_judge.sv
// Enemy spawn/approach timer and attack judge; press-to-pulse latency 4 clk edges.
// No backpressure: hit/damage are single-cycle pulses the consumer must take.
module attack_judge
  import attack_judge_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 12_500_000,
  parameter int unsigned START_POS  = 15,
  parameter int unsigned WINDOW     = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       fail,
  input  logic       btn_attack,
  output logic       hit,
  output logic       damage,
  output logic       enemy_valid,
  output logic [3:0] enemy_pos
);

  localparam int unsigned    CW    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0]  LAST  = CW'(STEP_TICKS - 1);
  localparam logic [3:0]     SPAWN = 4'(START_POS);
  localparam logic [3:0]     WIN   = 4'(WINDOW);

  logic          press;
  logic [1:0]    fsm;
  logic [CW-1:0] cnt;
  logic [3:0]    gap;
  logic [7:0]    lfsr;
  logic          run;
  logic          tick;
  logic [3:0]    gap_seed;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_attack),
    .press (press)
  );

  assign run      = (state != STATE_IDLE) && !fail;
  assign tick     = run && (fsm != FSM_IDLE) && (cnt == LAST);
  assign gap_seed = {1'b0, lfsr[2:0]} + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= FSM_IDLE;
      cnt         <= '0;
      gap         <= 4'd0;
      lfsr        <= LFSR_SEED;
      hit         <= 1'b0;
      damage      <= 1'b0;
      enemy_valid <= 1'b0;
      enemy_pos   <= 4'd0;
    end else begin
      hit    <= 1'b0;
      damage <= 1'b0;
      if (tick)
        lfsr <= lfsr_next(lfsr);

      if (!run) begin
        // LFSR is deliberately kept so the next round gets a fresh gap
        fsm         <= FSM_IDLE;
        cnt         <= '0;
        gap         <= 4'd0;
        enemy_valid <= 1'b0;
        enemy_pos   <= 4'd0;
      end else begin
        if (fsm == FSM_IDLE || tick)
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);

        case (fsm)
          FSM_IDLE: begin
            fsm <= FSM_WAIT;
            gap <= gap_seed;
          end
          FSM_WAIT: begin
            if (tick) begin
              if (gap <= 4'd1) begin
                fsm         <= FSM_APPROACH;
                gap         <= 4'd0;
                enemy_valid <= 1'b1;
                enemy_pos   <= SPAWN;
              end else begin
                gap <= gap - 4'd1;
              end
            end
          end
          FSM_APPROACH: begin
            // a press wins over a coincident tick and is judged on the pre-tick position
            if (press) begin
              if (enemy_pos <= WIN) begin
                hit         <= 1'b1;
                fsm         <= FSM_WAIT;
                gap         <= gap_seed;
                enemy_valid <= 1'b0;
                enemy_pos   <= 4'd0;
              end else begin
                damage <= 1'b1;
              end
            end else if (tick) begin
              if (enemy_pos == 4'd0) begin
                damage      <= 1'b1;
                fsm         <= FSM_WAIT;
                gap         <= gap_seed;
                enemy_valid <= 1'b0;
              end else begin
                enemy_pos <= enemy_pos - 4'd1;
              end
            end
          end
          default: fsm <= FSM_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/attack_judge.md
ATTACK_JUDGE -- requirements
Module: attack_judge

Interface
REQ-001 The parameter STEP_TICKS SHALL default to 12_500_000 and set the clk cycles per enemy step.
REQ-002 The parameter START_POS SHALL default to 15 and set the enemy spawn position (4-bit).
REQ-003 The parameter WINDOW SHALL default to 2 and set the highest position at which a press counts as a hit.
REQ-004 The parameter LFSR_SEED SHALL default to 8'hA5 and set the non-zero LFSR reset value.
REQ-005 Port clk: input, 1 bit, the single system clock; all logic SHALL be on its rising edge.
REQ-006 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-007 Port state: input, 4 bits, game state; 4'd0 means idle/menu.
REQ-008 Port fail: input, 1 bit, player-dead flag; while high, the block SHALL freeze.
REQ-009 Port btn_attack: input, 1 bit, debounced but unsynchronised attack button level.
REQ-010 Port hit: output, 1 bit, single-cycle pulse for a successful attack, feeding the player hit input.
REQ-011 Port damage: output, 1 bit, single-cycle pulse for a player penalty, feeding the player damage input.
REQ-012 Port enemy_valid: output, 1 bit, high while an enemy is on the track.
REQ-013 Port enemy_pos: output, 4 bits, current enemy position; 0 is the player position.

Function
REQ-014 btn_attack SHALL pass through a 2-flop synchroniser and a rising-edge detector, producing one press per 0->1 transition.
REQ-015 hit and damage SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-016 A step-tick counter SHALL count 0..STEP_TICKS-1 and emit a tick on wrap; it SHALL be held at 0 outside WAIT and APPROACH.
REQ-017 An 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance once per step tick and SHALL never reach zero.
REQ-018 The FSM SHALL have three states: IDLE, WAIT and APPROACH.
REQ-019 IDLE: enemy_valid=0 and no pulses; when state!=0 and fail=0, go to WAIT and load gap = lfsr[2:0]+1 steps.
REQ-020 WAIT: decrement gap on each tick; on the tick where gap reaches 0, go to APPROACH with enemy_pos=START_POS and enemy_valid=1.
REQ-021 APPROACH: on each tick, enemy_pos SHALL decrement by 1.
REQ-022 APPROACH: a press with enemy_pos<=WINDOW SHALL pulse hit, clear the enemy, reload gap, and go to WAIT.
REQ-023 APPROACH: a press with enemy_pos>WINDOW SHALL pulse damage (miss penalty), and the enemy SHALL continue.
REQ-024 APPROACH: a tick at enemy_pos==0 with no press SHALL pulse damage, clear the enemy, reload gap, and go to WAIT.
REQ-025 If a press and a tick occur in the same cycle, the press SHALL be judged against the pre-tick enemy_pos, and the tick SHALL be discarded.
REQ-026 Presses in IDLE or WAIT SHALL be ignored.
REQ-027 state==0 or fail==1 in any state SHALL force IDLE next cycle, clearing enemy, counters and any pending pulse; the LFSR SHALL be retained.
REQ-028 Press-to-pulse latency SHALL be exactly 4 clk edges from the first edge sampling btn_attack high (2 sync, 1 edge, 1 output register).

Reset
REQ-029 While rst is high, the block SHALL be in IDLE with hit=0, damage=0, enemy_valid=0, enemy_pos=0, tick counter=0, gap=0, synchroniser and edge flops=0, and LFSR=LFSR_SEED.
REQ-030 Reset assertion mid-APPROACH SHALL drop the enemy immediately and emit no pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the STATE_IDLE=4'd0 constant, and the LFSR tap constant.
REQ-032 The synchroniser plus edge detector SHALL be one sub-module, btn_edge, instantiated once; all other logic SHALL be in attack_judge.

Verification (STEP_TICKS=4, START_POS=15, WINDOW=2, seed 8'hA5)
REQ-033 Reset, then state=1: enemy_valid rises after (lfsr[2:0]+1)*4 cycles with enemy_pos=15, and no pulses occur.
REQ-034 No press: enemy_pos counts 15..0 every 4 cycles; one damage pulse follows the tick at pos 0; then the FSM is in WAIT.
REQ-035 Press at enemy_pos=2: exactly one hit pulse 4 edges later, enemy_valid=0, and damage=0.
REQ-036 Press at enemy_pos=9: one damage pulse, and the enemy keeps advancing to 8 on the next tick.
REQ-037 Press coinciding with the tick 1->0: hit pulse only, with no damage pulse.
REQ-038 fail=1 mid-approach: the next cycle has enemy_valid=0; a held or new press yields no pulse; rst mid-approach gives the same result with LFSR=8'hA5.
